// File: rtl/fifo_rr_scheduler.sv
// Round-robin scheduler: pops one of four input FIFOs per cycle into a shared
// output FIFO, stalls on output back-pressure and distributes the umbral value.
module fifo_rr_scheduler #(
    parameter int         BITNUMBER  = 6,
    parameter logic [2:0] UMBRAL_RST = 3'd1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   init,
    input  logic [2:0]             umbral_in,
    input  logic [3:0]             fifo_empty,
    input  logic [3:0]             fifo_valid,
    input  logic [4*BITNUMBER-1:0] fifo_data,
    input  logic                   out_almost_full,
    input  logic                   out_full,
    output logic [3:0]             fifo_rd,
    output logic                   out_wr,
    output logic [BITNUMBER-1:0]   out_data,
    output logic [2:0]             umbral_out,
    output logic [1:0]             state,
    output logic [1:0]             grant_id,
    output logic                   idle,
    output logic                   sched_error
);

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_INIT   = 2'd1,
        ST_IDLE   = 2'd2,
        ST_ACTIVE = 2'd3
    } state_t;

    state_t               state_reg, state_next;
    logic [3:0]           rd_reg, rd_next;
    logic [1:0]           grant_reg, grant_next;
    logic [2:0]           umbral_reg, umbral_next;
    logic [1:0]           inflight_reg, inflight_next;
    logic                 out_wr_reg;
    logic [BITNUMBER-1:0] out_data_reg;
    logic                 error_reg, error_next;

    logic [1:0]           rot_idx [4];
    logic [3:0]           rot_elig;
    logic [BITNUMBER-1:0] data_slice [4];
    logic [1:0]           pick_idx;
    logic [BITNUMBER-1:0] data_sel;
    logic                 pop_ok;
    logic                 inc;
    logic                 dec;
    logic                 multi_valid;

    // Candidate k is the FIFO k+1 positions after the last grant, so the
    // lowest eligible k is the round-robin winner.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] OFFS = 2'(gi + 1);
            assign rot_idx[gi]    = grant_reg + OFFS;
            assign rot_elig[gi]   = ~fifo_empty[rot_idx[gi]];
            assign data_slice[gi] = fifo_data[gi*BITNUMBER +: BITNUMBER];
        end
    endgenerate

    // Pick the first non-empty FIFO after the last grant.
    always_comb begin
        pick_idx = grant_reg;
        for (int k = 3; k >= 0; k--) begin
            if (rot_elig[k]) begin
                pick_idx = rot_idx[k];
            end
        end
    end

    // Select the data slice of the (lowest) valid lane for the push path.
    always_comb begin
        data_sel = '0;
        for (int k = 3; k >= 0; k--) begin
            if (fifo_valid[k]) begin
                data_sel = data_slice[k];
            end
        end
    end

    assign pop_ok = (state_reg == ST_ACTIVE) && !init && !out_almost_full &&
                    !out_full && (|rot_elig);

    // Next-state, umbral load and pop decision.
    always_comb begin
        state_next  = state_reg;
        umbral_next = umbral_reg;
        rd_next     = '0;
        grant_next  = grant_reg;
        case (state_reg)
            ST_RESET: state_next = ST_INIT;
            ST_INIT: begin
                if (init) begin
                    umbral_next = umbral_in;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (init) begin
                    state_next = ST_INIT;
                end else if (!(&fifo_empty) && !out_almost_full && !out_full) begin
                    state_next = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (init) begin
                    state_next = ST_INIT;
                end else if ((&fifo_empty) && (inflight_reg == 2'd0)) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_RESET;
        endcase
        if (pop_ok) begin
            rd_next    = 4'b0001 << pick_idx;
            grant_next = pick_idx;
        end
    end

    // The pop decision is a cycle old when it reaches the FIFO, so a lane that
    // ran dry in the meantime is masked off instead of being over-read.
    assign fifo_rd = rd_reg & ~fifo_empty;

    assign inc         = |fifo_rd;
    assign dec         = |fifo_valid;
    assign multi_valid = |(fifo_valid & (fifo_valid - 4'd1));

    // In-flight tracking (saturating) and sticky protocol-error detection.
    always_comb begin
        inflight_next = inflight_reg;
        if (inc && !dec && (inflight_reg != 2'd3)) begin
            inflight_next = inflight_reg + 2'd1;
        end else if (!inc && dec && (inflight_reg != 2'd0)) begin
            inflight_next = inflight_reg - 2'd1;
        end
        error_next = error_reg | multi_valid |
                     (dec && (inflight_reg == 2'd0)) | (dec && out_full);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_RESET;
            rd_reg       <= '0;
            grant_reg    <= 2'd3;
            umbral_reg   <= UMBRAL_RST;
            inflight_reg <= 2'd0;
            out_wr_reg   <= 1'b0;
            out_data_reg <= '0;
            error_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            rd_reg       <= rd_next;
            grant_reg    <= grant_next;
            umbral_reg   <= umbral_next;
            inflight_reg <= inflight_next;
            out_wr_reg   <= |fifo_valid;
            out_data_reg <= data_sel;
            error_reg    <= error_next;
        end
    end

    assign out_wr      = out_wr_reg;
    assign out_data    = out_data_reg;
    assign umbral_out  = umbral_reg;
    assign state       = state_reg;
    assign grant_id    = grant_reg;
    assign sched_error = error_reg;
    assign idle        = (state_reg == ST_IDLE) && (&fifo_empty) && (inflight_reg == 2'd0);

endmodule

// File: doc/fifo_rr_scheduler.md
Name: fifo_rr_scheduler

Overview:
- Sequences a bank of four input FIFOs (one per virtual channel) into one shared output FIFO.
- Each cycle it picks at most one non-empty input FIFO by round-robin and pops it. The popped word is forwarded to the output FIFO's write port.
- It stalls pops when the output FIFO signals almost-full or full.
- It also configures the threshold (umbral) value that all FIFOs use, through an init phase.

Parameters:
- BITNUMBER, 6, data word width of every FIFO.
- UMBRAL_RST, 1, umbral_out value loaded at reset.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- init  input  1  request configuration phase; umbral_in is sampled while high.
- umbral_in  input  3  threshold value to distribute.
- fifo_empty  input  4  Fifo_empty of input FIFOs 0..3.
- fifo_valid  input  4  valid_read of input FIFOs 0..3; data is present on fifo_data that cycle.
- fifo_data  input  4*BITNUMBER  Fifo_Data_out of FIFO i on bits [i*BITNUMBER +: BITNUMBER].
- out_almost_full  input  1  almost_full of the output FIFO.
- out_full  input  1  Fifo_full of the output FIFO.
- fifo_rd  output  4  one-hot-or-zero pop strobes to input FIFOs.
- out_wr  output  1  push strobe to the output FIFO.
- out_data  output  BITNUMBER  word pushed to the output FIFO.
- umbral_out  output  3  threshold driven to all FIFOs.
- state  output  2  RESET=0, INIT=1, IDLE=2, ACTIVE=3.
- grant_id  output  2  index of the last FIFO popped.
- idle  output  1  high when in IDLE, all fifo_empty bits are 1 and nothing is in flight.
- sched_error  output  1  sticky error flag.

Behaviour:
- Reset values: fifo_rd=0, out_wr=0, out_data=0, umbral_out=UMBRAL_RST, state=RESET, grant_id=3 (so the first grant is FIFO 0), idle=0, sched_error=0, in-flight counter=0.
- FSM transitions:
  - RESET goes to INIT unconditionally on the next cycle.
  - INIT: umbral_out is loaded from umbral_in on every cycle in which init=1. When init=0, go to IDLE.
  - IDLE: if init=1, go to INIT. Otherwise, if any fifo_empty bit is 0 and out_almost_full=0 and out_full=0, go to ACTIVE. Otherwise stay.
  - ACTIVE: if init=1, go to INIT; pops stop immediately, in-flight words still drain. Otherwise, if all fifo_empty bits are 1 and the in-flight count is 0, go to IDLE.
- Pops are issued only in ACTIVE and are registered: fifo_rd is high for exactly one cycle.
- Pop condition: a pop is issued when out_almost_full=0, out_full=0, init=0, and at least one eligible FIFO exists.
- Round-robin selection: search indices grant_id+1, grant_id+2, ... mod 4. Select the first index with fifo_empty=0 and update grant_id to it.
- Never assert fifo_rd[i] while fifo_empty[i]=1.
- Back-to-back pops of the same FIFO are allowed when it is the only non-empty one.
- Push path:
  - out_wr is registered from |fifo_valid (1-cycle latency).
  - out_data is registered from the fifo_data slice selected by fifo_valid.
  - Data words are never dropped. A word in flight when pause asserts is still written; the output FIFO's umbral margin absorbs it.
- In-flight counter (2 bits, range 0..3): increments on fifo_rd and decrements on a fifo_valid pulse. A simultaneous increment and decrement leaves it unchanged.
- sched_error is set, and held until reset, when any of these occur:
  - more than one fifo_valid bit is high;
  - a fifo_valid pulse arrives while the in-flight count is 0;
  - out_wr would assert while out_full=1.
- Reset asserted mid-operation: all state clears on the next edge and in-flight words are discarded.

Test Plan:
- Reset then init=1 with umbral_in=3 for 2 cycles, then init=0:
  - state goes 0→1→2;
  - umbral_out=3;
  - all strobes stay 0.
- FIFO 2 only non-empty, holding 3 words A,B,C; outputs idle:
  - fifo_rd=4'b0100 on 3 consecutive cycles;
  - out_wr pulses carry A,B,C in order;
  - state returns to IDLE; idle=1; sched_error=0.
- All four FIFOs non-empty with 2 words each:
  - grant order is 0,1,2,3,0,1,2,3;
  - 8 out_wr pulses carry data in that FIFO order.
- out_almost_full rises mid-stream:
  - no new fifo_rd on the following edge;
  - in-flight words are still pushed;
  - pops resume from the next round-robin index after the flag drops.
- init=1 during ACTIVE:
  - fifo_rd goes to 0 on the next edge;
  - pending valids are still written;
  - state=INIT and umbral_out updates.
- Inject fifo_valid=4'b0011, or a valid pulse with nothing in flight:
  - sched_error=1 and stays 1 until reset.
